div_unit: RTL and testbench

- Multi-cycle integer divider serving DIV/DIVU in the EX stage, alongside the combinational ALU.
- The ALU does not execute divides. The decoder raises `start` and this block computes {HI, LO}.
- The block asserts `busy` so the pipeline stalls EX. It pulses `ready` when the result may be written to HI/LO.
- Implementation: radix-2 restoring division, one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM state encodings and the
// decoder opcodes that launch DIV/DIVU.
package div_unit_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_ZERO = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    // Decoder ALU-op codes; EXE_DIV_OP drives start with signed_div = 1.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift in a dividend bit,
// try to subtract the divisor magnitude, keep the difference if no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_hi;

    assign shifted = {rem_i, bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
    assign q_o     = ~diff[WIDTH+1];

    // A kept value is always below the divisor, so the top bits are zero.
    assign rem_o     = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign unused_hi = ^{diff[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit, one quotient bit per clock.
// Optional macro DIV_SHORTCUT_EN: finish at once when |opa| < |opb|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         dbg_state_o
);

    // Handshake: start is accepted only in IDLE with annul low; busy stays
    // high from the cycle after acceptance through the ready cycle; ready is
    // a single-cycle pulse, suppressed by annul in that same cycle.

    logic [1:0]            state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      quo_q, quo_d;
    logic [WIDTH-1:0]      dvs_q, dvs_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic [2*WIDTH-1:0]    fin_q, fin_d;
    logic [2*WIDTH-1:0]    res_q, res_d;

    logic [WIDTH-1:0]      abs_a, abs_b;
    logic [WIDTH-1:0]      step_rem, step_quo;
    logic                  step_bit;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign abs_a = mag(opa, signed_div);
    assign abs_b = mag(opb, signed_div);

    // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    assign step_quo = {quo_q[WIDTH-2:0], step_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        fin_d   = fin_q;
        res_d   = res_q;

        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    negq_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    negr_d = signed_div & opa[WIDTH-1];
                    dvs_d  = abs_b;
                    quo_d  = abs_a;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (opb == '0) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d = DIV_BUSY;
`ifdef DIV_SHORTCUT_EN
                        if (abs_a < abs_b) begin
                            state_d = DIV_DONE;
                            fin_d   = {opa, {WIDTH{1'b0}}};
                        end
`endif
                    end
                end
            end
            DIV_BUSY: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + ITER_CNT_W'(1);
                    if (cnt_q == ITER_CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_DONE;
                        fin_d   = {(negr_q ? -step_rem : step_rem),
                                   (negq_q ? -step_quo : step_quo)};
                    end
                end
            end
            DIV_ZERO: begin
                // Two cycles here keep divide-by-zero completion at E2.
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    cnt_d = cnt_q + ITER_CNT_W'(1);
                    if (cnt_q == ITER_CNT_W'(1)) begin
                        state_d = DIV_DONE;
                        fin_d   = '0;
                    end
                end
            end
            default: begin
                state_d = DIV_IDLE;
                if (!annul) begin
                    res_d = fin_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            fin_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            fin_q   <= fin_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign ready       = (state_q == DIV_DONE) && !annul;
    assign result      = ready ? fin_q : res_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against an arithmetic reference model,
// plus literal checks of the documented divide cases.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy, ready;
    logic [63:0] result;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_held = '0;
    logic [63:0] exp_q[$];

    div_unit #(.WIDTH(32), .ITER_CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .opa         (opa),
        .opb         (opb),
        .annul       (annul),
        .busy        (busy),
        .ready       (ready),
        .result      (result),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        longint v;
        v = s ? longint'($signed(x)) : longint'({32'd0, x});
        if (v < 0) v = -v;
        return v[31:0];
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Number of clock edges after the start edge until the ready cycle begins.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return 2;
`ifdef DIV_SHORTCUT_EN
        if (mag(a, s) < mag(b, s)) return 0;
`else
        if (mag(a, s) > 32'hFFFF_FFFF) return 0;
`endif
        return 32;
    endfunction

    // Reference model: advances on each rising edge from the bench inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_held = '0;
            exp_q.delete();
        end else if (m_busy) begin
            if (annul) begin
                m_busy = 1'b0;
                void'(exp_q.pop_front());
            end else if (m_left == 0) begin
                m_busy = 1'b0;
                m_held = exp_q.pop_front();
            end else begin
                m_left--;
            end
        end else if (start && !annul) begin
            m_busy = 1'b1;
            m_left = ref_lat(opa, opb, signed_div);
            exp_q.push_back(ref_div(opa, opb, signed_div));
        end
    end

    // Cycle-by-cycle comparison of busy, ready and result against the model.
    initial begin
        logic        exp_rdy;
        logic [63:0] exp_res;
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                exp_rdy = m_busy && (m_left == 0) && !annul;
                exp_res = (exp_rdy && exp_q.size() > 0) ? exp_q[0] : m_held;
                check("busy", {63'd0, busy}, {63'd0, m_busy});
                check("ready", {63'd0, ready}, {63'd0, exp_rdy});
                check("result", result, exp_res);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        start = 1'b1;
        opa = a;
        opb = b;
        signed_div = s;
        @(negedge clk);
        start = 1'b0;
        opa = $urandom;
        opb = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [63:0] exp_res, input int exp_lat);
        int cyc;
        issue(a, b, s);
        wait_ready(cyc);
        check({name, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({name, "_res"}, result, exp_res);
    endtask

    initial begin
        int cyc;
        int seen;
        int short_lat;
        logic [31:0] a, b;
        logic        s;

`ifdef DIV_SHORTCUT_EN
        short_lat = 0;
`else
        short_lat = 32;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, DIV_IDLE});
        chk_en = 1'b1;
        rst = 1'b0;

        run_case("u7d2", 32'd7, 32'd2, 1'b0, 64'h00000001_00000003, 32);
        run_case("sm7d2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 32);
        run_case("s7dm2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 32);
        run_case("dz", 32'h12345678, 32'd0, 1'b0, 64'd0, 2);
        @(negedge clk);
        #1;
        check("dz_busy_rel", {63'd0, busy}, 64'd0);
        run_case("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 32);
        run_case("u_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 32);
        run_case("short", 32'd3, 32'd100, 1'b0, 64'h00000003_00000000, short_lat);

        // start together with annul in IDLE launches nothing
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opa = 32'd50; opb = 32'd5;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        check("sa_busy", {63'd0, busy}, 64'd0);

        // annul mid-divide; a second start during BUSY must be ignored
        issue(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = (k == 4);
            opa = 32'd999;
            annul = (k == 10);
        end
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("an_state", {62'd0, dbg_state}, {62'd0, DIV_IDLE});
        check("an_busy", {63'd0, busy}, 64'd0);
        check("an_hold", result, 64'h00000003_00000000);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (ready) seen++;
        end
        check("an_noready", 64'(seen), 64'd0);

        // synchronous reset in the middle of a divide
        issue(32'd1000, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_res", result, 64'd0);

        // randomized divides with occasional annul and held start
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            issue(a, b, s);
            cyc = 0;
            while (busy && cyc < 100) begin
                @(negedge clk);
                annul = ($urandom_range(0, 40) == 0);
                start = ($urandom_range(0, 9) == 0);
                #1;
                cyc++;
            end
            annul = 1'b0;
            start = 1'b0;
            check("rand_timeout", {63'd0, (cyc < 100)}, 64'd1);
            // a start held into the IDLE cycle may launch one more divide
            cyc = 0;
            while (busy && cyc < 100) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
